conv_mac_seq: RTL

- Sequencer that time-shares one fixed-point multiply path across the KERNEL_SIZE*KERNEL_SIZE taps of a convolution window.
- Accepts a start pulse, then streams (pixel, weight) pairs with a valid/ready handshake.
- Multiplies each pair with the codebase's Q(DATA_WIDTH-FRAC_BIT).FRAC_BIT arithmetic, accumulates the products and returns one saturated result per window.
- Sits between the window/line-buffer feeder and the output writer in the convolver.

---
 rtl/conv_mac_seq.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/conv_mac_seq.sv
// conv_mac_seq: time-shares one fixed-point multiplier across the
// KERNEL_SIZE*KERNEL_SIZE taps of a convolution window.
// Each accepted (pixel, weight) pair is multiplied and floor-truncated to
// Q(DATA_WIDTH-FRAC_BIT).FRAC_BIT. The product is registered, then added
// into a wide accumulator on the following edge. The window sum is clamped
// to DATA_WIDTH bits and presented on a valid/ready output.
// The OUTPUT state has two phases. On the first edge the clamped sum is
// captured into the output registers. After that, the result is held until
// the downstream handshake. This gives a result two edges after the last
// accepted tap.

module conv_mac_seq #(
    parameter int DATA_WIDTH  = 16,
    parameter int FRAC_BIT    = 8,
    parameter int KERNEL_SIZE = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_pixel,
    input  logic [DATA_WIDTH-1:0] in_weight,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_sat
);

    localparam int TAPS  = KERNEL_SIZE * KERNEL_SIZE;
    localparam int ACC_W = DATA_WIDTH + 4;
    // Accumulator bits that must agree with the result sign bit when no clamp is needed
    localparam int HI_W  = ACC_W - DATA_WIDTH + 1;
    localparam logic [4:0] LAST_TAP = 5'(TAPS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_DRAIN  = 2'd2,
        S_OUTPUT = 2'd3
    } state_t;

    // Clamp the accumulator to the signed DATA_WIDTH range; returns {sat, data}
    function automatic logic [DATA_WIDTH:0] clamp_acc(input logic [ACC_W-1:0] a);
        logic [HI_W-1:0] hi;
        logic [DATA_WIDTH:0] res;
        hi = a[ACC_W-1:DATA_WIDTH-1];
        if ((hi == {HI_W{1'b0}}) || (hi == {HI_W{1'b1}})) begin
            res = {1'b0, a[DATA_WIDTH-1:0]};
        end else if (a[ACC_W-1] == 1'b0) begin
            res = {1'b1, 1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else begin
            res = {1'b1, 1'b1, {(DATA_WIDTH-1){1'b0}}};
        end
        return res;
    endfunction

    state_t                  state_r,     state_next_s;
    logic [ACC_W-1:0]        acc_r,       acc_next_s;
    logic [DATA_WIDTH-1:0]   prod_r,      prod_next_s;
    logic                    prod_vld_r,  prod_vld_next_s;
    logic [4:0]              tap_cnt_r,   tap_cnt_next_s;
    logic                    busy_r,      busy_next_s;
    logic                    in_ready_r,  in_ready_next_s;
    logic                    out_valid_r, out_valid_next_s;
    logic [DATA_WIDTH-1:0]   out_data_r,  out_data_next_s;
    logic                    out_sat_r,   out_sat_next_s;

    logic signed [2*DATA_WIDTH-1:0] full_prod_s;
    logic [DATA_WIDTH-1:0]          prod_trunc_s;
    logic [ACC_W-1:0]               prod_ext_s;
    logic [DATA_WIDTH:0]            clamp_s;
    logic                           accept_s;
    logic                           prod_unused_s;

    assign full_prod_s   = $signed(in_pixel) * $signed(in_weight);
    // Floor truncation: keep the integer/fraction window, wrap on overflow
    assign prod_trunc_s  = full_prod_s[DATA_WIDTH+FRAC_BIT-1:FRAC_BIT];
    assign prod_unused_s = ^{full_prod_s[2*DATA_WIDTH-1:DATA_WIDTH+FRAC_BIT],
                             full_prod_s[FRAC_BIT-1:0]};
    assign prod_ext_s    = {{(ACC_W-DATA_WIDTH){prod_r[DATA_WIDTH-1]}}, prod_r};
    assign clamp_s       = clamp_acc(acc_r);
    // in_ready_r is only high in LOAD, so this also gates on state
    assign accept_s      = in_valid & in_ready_r;

    assign busy      = busy_r;
    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_sat   = out_sat_r;

    // Next-state and next-register computation for the window sequencer
    always_comb begin
        state_next_s     = state_r;
        acc_next_s       = acc_r;
        prod_next_s      = prod_r;
        prod_vld_next_s  = prod_vld_r;
        tap_cnt_next_s   = tap_cnt_r;
        out_valid_next_s = out_valid_r;
        out_data_next_s  = out_data_r;
        out_sat_next_s   = out_sat_r;

        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_next_s    = S_LOAD;
                    acc_next_s      = {ACC_W{1'b0}};
                    tap_cnt_next_s  = 5'd0;
                    prod_vld_next_s = 1'b0;
                end else begin
                    state_next_s    = S_IDLE;
                end
            end
            S_LOAD: begin
                if (prod_vld_r) begin
                    acc_next_s = acc_r + prod_ext_s;
                end else begin
                    acc_next_s = acc_r;
                end
                if (accept_s) begin
                    prod_next_s     = prod_trunc_s;
                    prod_vld_next_s = 1'b1;
                    tap_cnt_next_s  = tap_cnt_r + 5'd1;
                    if (tap_cnt_r == LAST_TAP) begin
                        state_next_s = S_DRAIN;
                    end else begin
                        state_next_s = S_LOAD;
                    end
                end else begin
                    prod_vld_next_s = 1'b0;
                end
            end
            S_DRAIN: begin
                if (prod_vld_r) begin
                    acc_next_s = acc_r + prod_ext_s;
                end else begin
                    acc_next_s = acc_r;
                end
                prod_vld_next_s = 1'b0;
                state_next_s    = S_OUTPUT;
            end
            S_OUTPUT: begin
                if (!out_valid_r) begin
                    // First OUTPUT edge: capture the clamped window sum
                    out_valid_next_s = 1'b1;
                    out_sat_next_s   = clamp_s[DATA_WIDTH];
                    out_data_next_s  = clamp_s[DATA_WIDTH-1:0];
                end else if (out_ready) begin
                    out_valid_next_s = 1'b0;
                    out_sat_next_s   = 1'b0;
                    out_data_next_s  = {DATA_WIDTH{1'b0}};
                    state_next_s     = S_IDLE;
                end else begin
                    state_next_s     = S_OUTPUT;
                end
            end
            default: begin
                state_next_s     = S_IDLE;
                out_valid_next_s = 1'b0;
                out_sat_next_s   = 1'b0;
                out_data_next_s  = {DATA_WIDTH{1'b0}};
            end
        endcase

        busy_next_s     = (state_next_s != S_IDLE);
        in_ready_next_s = (state_next_s == S_LOAD);
    end

    // State, datapath and registered-output update with async reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= S_IDLE;
            acc_r       <= {ACC_W{1'b0}};
            prod_r      <= {DATA_WIDTH{1'b0}};
            prod_vld_r  <= 1'b0;
            tap_cnt_r   <= 5'd0;
            busy_r      <= 1'b0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= {DATA_WIDTH{1'b0}};
            out_sat_r   <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            acc_r       <= acc_next_s;
            prod_r      <= prod_next_s;
            prod_vld_r  <= prod_vld_next_s;
            tap_cnt_r   <= tap_cnt_next_s;
            busy_r      <= busy_next_s;
            in_ready_r  <= in_ready_next_s;
            out_valid_r <= out_valid_next_s;
            out_data_r  <= out_data_next_s;
            out_sat_r   <= out_sat_next_s;
        end
    end

endmodule
